// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//
// Purpose:
//   A chain of DEPTH register stages. Each stage holds an N-bit data word and
//   a valid bit. The chain can advance one stage per cycle, stall (hold every
//   stage), or flush (load every stage with a bubble).
//
//   Control priority on each rising edge is flush, then enable, then stall.
//   A registered occupancy count tracks how many stages hold valid words.
//
// Ports:
//   clk          in   1         rising-edge clock for all state
//   reset        in   1         asynchronous, active-low reset
//   enable       in   1         1 = advance one stage, 0 = stall (hold)
//   flush        in   1         1 = all stages load BUBBLE_VALUE, invalid;
//                               overrides enable
//   in_valid     in   1         qualifies Pipe_Input
//   Pipe_Input   in   N         data into stage 0
//   Pipe_Output  out  N         data of the last stage (register output)
//   out_valid    out  1         valid bit of the last stage
//   occupancy    out  OCC_W     registered count of valid stages, 0..DEPTH
//   stall_count  out  16        saturating count of stall cycles taken
//                               while the chain was occupied
//
// Configuration:
//   PIPE_STALL_CNT_EN  When this macro is defined, the stall_count port and
//                      its counter are built. When it is undefined, they are
//                      absent and all other behaviour is unchanged.
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
    parameter int unsigned         N            = 32,
    parameter int unsigned         DEPTH        = 2,
    parameter logic [N-1:0]        RESET_VALUE  = N'(32'h0040_0000),
    parameter logic [N-1:0]        BUBBLE_VALUE = '0,
    localparam int unsigned        OCC_W        = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [N-1:0]       Pipe_Input,
    output logic [N-1:0]       Pipe_Output,
    output logic               out_valid,
`ifdef PIPE_STALL_CNT_EN
    output logic [OCC_W-1:0]   occupancy,
    output logic [15:0]        stall_count
`else
    output logic [OCC_W-1:0]   occupancy
`endif
);

    logic [N-1:0]     data_q  [DEPTH];
    logic [N-1:0]     data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Next-state logic for the stages and the occupancy count.
    always_comb begin
        // NOTE: each signal gets a hold value first. Without it, a path that
        // skips an assignment would infer a latch.
        data_d  = data_q;
        valid_d = valid_q;
        occ_d   = occ_q;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = BUBBLE_VALUE;
            end
            valid_d = '0;
            occ_d   = '0;
        end else if (enable) begin
            data_d[0]  = Pipe_Input;
            valid_d[0] = in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            // One word enters and the word in the last stage leaves. The sum
            // may pass through OCC_W overflow when occ_q == DEPTH, but modular
            // arithmetic still returns the correct final count.
            occ_d = occ_q + OCC_W'(in_valid) - OCC_W'(valid_q[DEPTH-1]);
        end
    end

    // Stage registers and occupancy.
    // NOTE: the data words are reset here on purpose, not left as
    // uninitialised storage. The last stage drives Pipe_Output directly, and
    // it must show RESET_VALUE while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VALUE;
            end
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. Every
            // stage then samples the value its neighbour held before the edge.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // A cycle counts as a stall only if the chain holds at least one valid
    // word. Flush has priority over stall, so a flush cycle never counts.
    // A flush does not clear the counter; only reset does.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!flush && !enable && (occ_q != '0) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

    // Every output comes straight from a register. No input has a
    // combinational path to an output.
    assign Pipe_Output = data_q[DEPTH-1];
    assign out_valid   = valid_q[DEPTH-1];
    assign occupancy   = occ_q;

endmodule
